ram8x8_sync: RTL and testbench
==============================

RAM8X8_SYNC -- requirements
Module: ram8x8_sync

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, word width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 3, address width; depth = 2**ADDR_W = 8 words.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port entrada, input, DATA_W bits: write data.
REQ-006 The block SHALL have port a, input, ADDR_W bits: word address, shared by read and write.
REQ-007 The block SHALL have port rw, input, 1 bit: 1 = write enable, 0 = read only.
REQ-008 The block SHALL have port s, output, DATA_W bits: read data.

Function
REQ-009 The block SHALL store 8 independent words of DATA_W bits each.
REQ-010 Write: on rising clk with clear=0 and rw=1, the block SHALL load entrada into word a; all other words hold.
REQ-011 With rw=0 and clear=0, the block SHALL leave every word unchanged.
REQ-012 Read: s SHALL equal word[a] combinationally (zero-cycle latency), for any rw value.
REQ-013 After a write, s SHALL show the new data from the clock edge that performs the write, when a is unchanged.
REQ-014 A change of a SHALL change s in the same cycle, with no clock needed.
REQ-015 The address SHALL use the full range 0..7 with no wrap or out-of-range case; every value selects exactly one word.
REQ-016 Changes on entrada or a between clock edges SHALL NOT alter stored contents.
REQ-017 Only the values of entrada, a and rw sampled at the rising edge SHALL determine the write.

Reset
REQ-018 On rising clk with clear=1, the block SHALL set all 8 words to 0.
REQ-019 clear SHALL take priority over rw=1 in the same cycle: all words clear and no write occurs.
REQ-020 After reset, s SHALL read 0 at every address.
REQ-021 Before the first reset, memory contents are undefined and no particular value is required.
REQ-022 Asserting clear mid-sequence SHALL discard all prior writes at that edge.

Structure
REQ-023 A shared package SHALL hold DATA_W, ADDR_W and DEPTH constants.
REQ-024 The block SHALL contain one sub-module, dmx3bits: a 3-to-8 one-hot decoder (enable, address) -> 8 word-select lines.
REQ-025 Each word's write enable SHALL be select[i] AND rw.
REQ-026 The read path SHALL be an 8:1 multiplexer on a.
REQ-027 Clock gating SHALL NOT be used; write enables feed flop enable logic on clk.

Verification
REQ-028 Reset: pulse clear=1 for one edge, then sweep a=0..7 with rw=0 -> s=0x00 at every address.
REQ-029 Walking ones: with rw=1, write entrada=0x01<<k to a=k for k=0..7; then with rw=0 read a=0..7 -> s=0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80.
REQ-030 Read only: rw=0, a=3, entrada=0xFF for several edges -> s stays 0x08 and no word changes.
REQ-031 Priority: clear=1 and rw=1, a=5, entrada=0xAA on the same edge -> all words 0, s=0x00.
REQ-032 Overwrite: write 0x5A then 0xA5 to a=2 -> s=0xA5 after the second edge; a=1 and a=3 unaffected.
REQ-033 Combinational read: change a between edges with rw=0 -> s follows the stored word immediately.

Source files
------------

// File: rtl/ram8x8_sync_pkg.sv
// ram8x8_sync shared constants
// Word width, address width and depth of the 8x8 register file.
package ram8x8_sync_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

endpackage

// File: rtl/ram8x8_sync_dmx3bits.sv
// dmx3bits: 3-to-8 one-hot decoder
// Drives exactly one select line high for the given address when enabled.
module dmx3bits
    import ram8x8_sync_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic              en,
    input  logic [AW-1:0]     addr,
    output logic [(1<<AW)-1:0] sel
);

    // one-hot select of the addressed word
    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/ram8x8_sync.sv
// ram8x8_sync: 8-word synchronous-write, asynchronous-read RAM
// Decoded per-word write enables, synchronous clear of every word.
module ram8x8_sync #(
    parameter int DATA_W = ram8x8_sync_pkg::DATA_W,
    parameter int ADDR_W = ram8x8_sync_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [DATA_W-1:0] entrada,
    input  logic [ADDR_W-1:0] a,
    input  logic              rw,
    output logic [DATA_W-1:0] s
);

    localparam int WORDS = 1 << ADDR_W;

    logic [WORDS-1:0]  sel;
    logic [WORDS-1:0]  we;
    logic [DATA_W-1:0] mem [WORDS];

    dmx3bits #(
        .AW   (ADDR_W)
    ) u_dec (
        .en   (1'b1),
        .addr (a),
        .sel  (sel)
    );

    assign we = sel & {WORDS{rw}};

    // word storage: clear wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (we[i]) begin
                    mem[i] <= entrada;
                end
            end
        end
    end

    // combinational 8:1 read mux on the shared address
    always_comb begin
        s = mem[a];
    end

endmodule

// File: tb/tb_ram8x8_sync.sv
// tb_ram8x8_sync: directed and randomized checks of ram8x8_sync
// Reference is a plain array updated with the write/clear rules.
module tb_ram8x8_sync;

    logic       clk;
    logic       clear;
    logic [7:0] entrada;
    logic [2:0] a;
    logic       rw;
    logic [7:0] s;

    logic [7:0] model [8];
    int         n_checks;
    int         n_fail;

    ram8x8_sync dut (
        .clk     (clk),
        .clear   (clear),
        .entrada (entrada),
        .a       (a),
        .rw      (rw),
        .s       (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input logic c, input logic w,
                         input logic [2:0] ad, input logic [7:0] d);
        clear   = c;
        rw      = w;
        a       = ad;
        entrada = d;
        @(posedge clk);
        if (c) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (w) begin
            model[ad] = d;
        end
        #1;
        clear = 1'b0;
        rw    = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            n_checks++;
            if (s !== 8'h00) begin
                n_fail++;
                $display("FAIL reset a=%0d got=%h exp=00", i, s);
            end
        end
    endtask

    task automatic test_walking_ones();
        logic [7:0] one;
        logic [7:0] exp;
        one = 8'h01;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 3'(k), one << k);
        end
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            exp = one << i;
            n_checks++;
            if (s !== exp) begin
                n_fail++;
                $display("FAIL walk a=%0d got=%h exp=%h", i, s, exp);
            end
        end
    endtask

    task automatic test_read_only();
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0, 1'b0, 3'd3, 8'hFF);
            n_checks++;
            if (s !== 8'h08) begin
                n_fail++;
                $display("FAIL readonly edge=%0d got=%h exp=08", n, s);
            end
        end
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            n_checks++;
            if (s !== model[i]) begin
                n_fail++;
                $display("FAIL readonly_hold a=%0d got=%h exp=%h",
                         i, s, model[i]);
            end
        end
    endtask

    task automatic test_priority();
        clear   = 1'b1;
        rw      = 1'b1;
        a       = 3'd5;
        entrada = 8'hAA;
        @(posedge clk);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        #1;
        n_checks++;
        if (s !== 8'h00) begin
            n_fail++;
            $display("FAIL priority a=5 got=%h exp=00", s);
        end
        clear = 1'b0;
        rw    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            n_checks++;
            if (s !== 8'h00) begin
                n_fail++;
                $display("FAIL priority_all a=%0d got=%h exp=00", i, s);
            end
        end
    endtask

    task automatic test_overwrite();
        cycle(1'b0, 1'b1, 3'd1, 8'h11);
        cycle(1'b0, 1'b1, 3'd3, 8'h33);
        cycle(1'b0, 1'b1, 3'd2, 8'h5A);
        n_checks++;
        if (s !== 8'h5A) begin
            n_fail++;
            $display("FAIL overwrite_first got=%h exp=5a", s);
        end
        cycle(1'b0, 1'b1, 3'd2, 8'hA5);
        n_checks++;
        if (s !== 8'hA5) begin
            n_fail++;
            $display("FAIL overwrite_second got=%h exp=a5", s);
        end
        a = 3'd1;
        #1;
        n_checks++;
        if (s !== 8'h11) begin
            n_fail++;
            $display("FAIL overwrite_a1 got=%h exp=11", s);
        end
        a = 3'd3;
        #1;
        n_checks++;
        if (s !== 8'h33) begin
            n_fail++;
            $display("FAIL overwrite_a3 got=%h exp=33", s);
        end
    endtask

    task automatic test_comb_read();
        logic [2:0] ad;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 3'(i), 8'($urandom));
        end
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            ad = 3'($urandom_range(0, 7));
            a  = ad;
            #1;
            n_checks++;
            if (s !== model[ad]) begin
                n_fail++;
                $display("FAIL comb a=%0d got=%h exp=%h", ad, s, model[ad]);
            end
        end
    endtask

    task automatic test_random();
        logic       c;
        logic       w;
        logic [2:0] ad;
        logic [7:0] d;
        for (int n = 0; n < 300; n++) begin
            c  = ($urandom_range(0, 15) == 0);
            w  = 1'($urandom);
            ad = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            cycle(c, w, ad, d);
            n_checks++;
            if (s !== model[ad]) begin
                n_fail++;
                $display("FAIL random n=%0d a=%0d got=%h exp=%h",
                         n, ad, s, model[ad]);
            end
            entrada = 8'($urandom);
            ad      = 3'($urandom_range(0, 7));
            a       = ad;
            #1;
            n_checks++;
            if (s !== model[ad]) begin
                n_fail++;
                $display("FAIL random_between n=%0d a=%0d got=%h exp=%h",
                         n, ad, s, model[ad]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            n_checks++;
            if (s !== model[i]) begin
                n_fail++;
                $display("FAIL random_final a=%0d got=%h exp=%h",
                         i, s, model[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear    = 1'b0;
        rw       = 1'b0;
        a        = 3'd0;
        entrada  = 8'h00;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_walking_ones();
        test_read_only();
        test_priority();
        test_overwrite();
        test_comb_read();
        test_random();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
